// File: rtl/intersection_sequencer.sv
// intersection_sequencer: self-timed traffic-light controller for NUM_ROADS
// approaches served round-robin. Each road's turn runs LEFT (only when a
// left-turn request is latched) -> GREEN -> YELLOW -> ALLRED, then the next
// road takes over. Lamps are a Moore decode of the road/phase registers.
// phaseOut and roadOut expose the FSM state directly.
module intersection_sequencer #(
    parameter int NUM_ROADS    = 2,
    parameter int TICK_DIV     = 50000000,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int LEFT_TICKS   = 8,
    localparam int ROAD_W      = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ROADS-1:0] leftReq,
    output logic [NUM_ROADS-1:0] greenOut,
    output logic [NUM_ROADS-1:0] redOut,
    output logic [NUM_ROADS-1:0] yellowOut,
    output logic [NUM_ROADS-1:0] leftOut,
    output logic [ROAD_W-1:0]    roadOut,
    output logic [1:0]           phaseOut,
    output logic [NUM_ROADS-1:0] leftPending
);

    // Timer must hold the largest duration minus one; one spare bit on top.
    localparam int MAX_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_AL  = (ALLRED_TICKS > LEFT_TICKS) ? ALLRED_TICKS : LEFT_TICKS;
    localparam int MAX_DUR = (MAX_GY > MAX_AL) ? MAX_GY : MAX_AL;
    localparam int TW      = $clog2(MAX_DUR) + 1;
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Widened by one bit so the range check is meaningful for any NUM_ROADS.
    localparam logic [ROAD_W:0] ROAD_LIMIT = (ROAD_W + 1)'(NUM_ROADS);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_LEFT   = 2'd3
    } phase_t;

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [TW-1:0]        timer, timer_n;
    logic [TW-1:0]        dur_last;
    logic [ROAD_W-1:0]    road, road_n, nr;
    phase_t               phase, phase_n;
    logic                 road_valid;
    logic [NUM_ROADS-1:0] pend_clr;
    logic [NUM_ROADS-1:0] pend_n;

    // With TICK_DIV=1 the counter sits at 0 and tick stays high.
    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign road_valid = ({1'b0, road} < ROAD_LIMIT);
    // Explicit wrap so non-power-of-two road counts are handled.
    assign nr         = (road == ROAD_W'(NUM_ROADS - 1)) ? '0 : road + ROAD_W'(1);

    // Prescaler: free-running 0..TICK_DIV-1 counter producing the timing tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Last timer value of the current phase (duration minus one).
    always_comb begin
        dur_last = TW'(GREEN_TICKS - 1);
        case (phase)
            PH_GREEN:  dur_last = TW'(GREEN_TICKS - 1);
            PH_YELLOW: dur_last = TW'(YELLOW_TICKS - 1);
            PH_ALLRED: dur_last = TW'(ALLRED_TICKS - 1);
            PH_LEFT:   dur_last = TW'(LEFT_TICKS - 1);
            default:   dur_last = TW'(GREEN_TICKS - 1);
        endcase
    end

    // Next-state logic: dwell timing, phase sequencing and left-request service.
    always_comb begin
        road_n   = road;
        phase_n  = phase;
        timer_n  = timer;
        pend_clr = '0;
        if (!road_valid) begin
            // Recovery from an impossible road index: restart at road 0 green.
            road_n  = '0;
            phase_n = PH_GREEN;
            timer_n = '0;
        end else if (tick) begin
            if (timer == dur_last) begin
                timer_n = '0;
                case (phase)
                    PH_LEFT:   phase_n = PH_GREEN;
                    PH_GREEN:  phase_n = PH_YELLOW;
                    PH_YELLOW: phase_n = PH_ALLRED;
                    PH_ALLRED: begin
                        road_n = nr;
                        // A request arriving this very cycle is served now and
                        // never shows up as pending.
                        if (leftPending[nr] || leftReq[nr]) begin
                            phase_n      = PH_LEFT;
                            pend_clr[nr] = 1'b1;
                        end else begin
                            phase_n = PH_GREEN;
                        end
                    end
                    default: begin
                        road_n  = '0;
                        phase_n = PH_GREEN;
                    end
                endcase
            end else begin
                timer_n = timer + TW'(1);
            end
        end
    end

    // Clear beats set: the road entering LEFT has its request consumed.
    assign pend_n = (leftPending | leftReq) & ~pend_clr;

    // State registers: road, phase, dwell timer and latched left requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            road        <= '0;
            phase       <= PH_GREEN;
            timer       <= '0;
            leftPending <= '0;
        end else begin
            road        <= road_n;
            phase       <= phase_n;
            timer       <= timer_n;
            leftPending <= pend_n;
        end
    end

    // Lamp decode: only the active road shows anything other than red.
    always_comb begin
        greenOut  = '0;
        yellowOut = '0;
        leftOut   = '0;
        redOut    = '1;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (road_valid && (road == ROAD_W'(i))) begin
                greenOut[i]  = (phase == PH_GREEN);
                yellowOut[i] = (phase == PH_YELLOW);
                leftOut[i]   = (phase == PH_LEFT);
                redOut[i]    = (phase == PH_ALLRED) || (phase == PH_LEFT);
            end
        end
    end

    assign roadOut  = road;
    assign phaseOut = phase;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: two instances (2 roads / tick every cycle,
// and 3 roads / tick every 3 cycles) checked each cycle against a phase-schedule
// model, plus directed literal expectations along a fixed timeline.
module tb_intersection_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT signals ----------------
    logic [1:0] req_a, g_a, r_a, y_a, l_a, pd_a, ph_a;
    logic [0:0] rd_a;
    logic [2:0] req_b, g_b, r_b, y_b, l_b, pd_b;
    logic [1:0] rd_b, ph_b;

    intersection_sequencer #(
        .NUM_ROADS(2), .TICK_DIV(1), .GREEN_TICKS(4),
        .YELLOW_TICKS(2), .ALLRED_TICKS(1), .LEFT_TICKS(3)
    ) dut_a (
        .clk(clk), .reset(reset), .leftReq(req_a),
        .greenOut(g_a), .redOut(r_a), .yellowOut(y_a), .leftOut(l_a),
        .roadOut(rd_a), .phaseOut(ph_a), .leftPending(pd_a)
    );

    intersection_sequencer #(
        .NUM_ROADS(3), .TICK_DIV(3), .GREEN_TICKS(4),
        .YELLOW_TICKS(2), .ALLRED_TICKS(1), .LEFT_TICKS(3)
    ) dut_b (
        .clk(clk), .reset(reset), .leftReq(req_b),
        .greenOut(g_b), .redOut(r_b), .yellowOut(y_b), .leftOut(l_b),
        .roadOut(rd_b), .phaseOut(ph_b), .leftPending(pd_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc;

    // ---------------- behavioural model ----------------
    // Phase codes: 0 green, 1 yellow, 2 all-red, 3 left. 'left' counts clock
    // cycles remaining in the current phase.
    typedef struct {
        int road;
        int phase;
        int left;
        int pend;
    } mstate_t;

    mstate_t ma, mb;

    function automatic int dur_ticks(input int ph);
        case (ph)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic mstate_t mreset(input int div);
        mstate_t s;
        s.road  = 0;
        s.phase = 0;
        s.left  = 4 * div;
        s.pend  = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int req, input int nroads, input int div);
        mstate_t n;
        n      = s;
        n.pend = s.pend | req;
        n.left = s.left - 1;
        if (n.left == 0) begin
            case (s.phase)
                3: n.phase = 0;
                0: n.phase = 1;
                1: n.phase = 2;
                default: begin
                    n.road = (s.road + 1) % nroads;
                    if (((n.pend >> n.road) & 1) != 0) begin
                        n.phase = 3;
                        n.pend  = n.pend & ~(1 << n.road);
                    end else begin
                        n.phase = 0;
                    end
                end
            endcase
            n.left = dur_ticks(n.phase) * div;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma  <= mreset(1);
            mb  <= mreset(3);
            cyc <= 0;
        end else begin
            ma  <= mstep(ma, int'(req_a), 2, 1);
            mb  <= mstep(mb, int'(req_b), 3, 3);
            cyc <= cyc + 1;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model(input string tag, input mstate_t m, input int n,
                               input logic [31:0] g, input logic [31:0] r,
                               input logic [31:0] y, input logic [31:0] l,
                               input logic [31:0] rd, input logic [31:0] ph,
                               input logic [31:0] pd);
        logic [31:0] lit, all, eg, er, ey, el;
        lit = 32'(1) << m.road;
        all = (32'(1) << n) - 32'(1);
        eg  = (m.phase == 0) ? lit : 32'(0);
        ey  = (m.phase == 1) ? lit : 32'(0);
        el  = (m.phase == 3) ? lit : 32'(0);
        er  = all & ~(((m.phase == 0) || (m.phase == 1)) ? lit : 32'(0));
        checks++;
        if ({g, r, y, l, rd, ph, pd} !== {eg, er, ey, el, 32'(m.road), 32'(m.phase), 32'(m.pend)}) begin
            errors++;
            $display("FAIL model_%s (cyc %0d): got g=%0h r=%0h y=%0h l=%0h road=%0h ph=%0h pend=%0h expected g=%0h r=%0h y=%0h l=%0h road=%0d ph=%0d pend=%0h",
                     tag, cyc, g, r, y, l, rd, ph, pd, eg, er, ey, el, m.road, m.phase, m.pend);
        end
    endtask

    task automatic check_onehot(input string tag, input logic [31:0] lamps);
        checks++;
        if ($countones(lamps) > 1) begin
            errors++;
            $display("FAIL lamp_invariant_%s (cyc %0d): got %0h expected at most one bit", tag, cyc, lamps);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check_model("A", ma, 2, 32'(g_a), 32'(r_a), 32'(y_a), 32'(l_a), 32'(rd_a), 32'(ph_a), 32'(pd_a));
        check_model("B", mb, 3, 32'(g_b), 32'(r_b), 32'(y_b), 32'(l_b), 32'(rd_b), 32'(ph_b), 32'(pd_b));
        check_onehot("A", 32'(g_a | y_a | l_a));
        check_onehot("B", 32'(g_b | y_b | l_b));
    end

    // ---------------- driver tasks ----------------
    // Wait (bounded) for the falling edge where the cycle counter equals k.
    task automatic at_cyc(input int k);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 500) begin
            @(negedge clk);
            if (cyc == k) done = 1'b1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL at_cyc_timeout: got cyc %0d expected %0d", cyc, k);
        end
    endtask

    // ---------------- directed timeline ----------------
    initial begin
        reset = 1'b1;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Free-running cycle for road A, reset-state lamps.
        at_cyc(1);  check("a_g_k1", 32'(g_a), 32'h1); check("a_r_k1", 32'(r_a), 32'h2);
                    check("a_ph_k1", 32'(ph_a), 0);
        at_cyc(4);  check("a_y_k4", 32'(y_a), 32'h1); check("a_ph_k4", 32'(ph_a), 1);
        at_cyc(6);  check("a_r_k6", 32'(r_a), 32'h3); check("a_ph_k6", 32'(ph_a), 2);
                    check("a_g_k6", 32'(g_a), 0);
        at_cyc(7);  check("a_g_k7", 32'(g_a), 32'h2); check("a_rd_k7", 32'(rd_a), 1);
        at_cyc(11); check("b_g_k11", 32'(g_b), 32'h1); check("b_ph_k11", 32'(ph_b), 0);
        at_cyc(12); check("b_y_k12", 32'(y_b), 32'h1); check("b_ph_k12", 32'(ph_b), 1);
        at_cyc(14); check("a_g_k14", 32'(g_a), 32'h1);

        // Left request for road 1 during road 0 green.
        at_cyc(15); req_a = 2'b10;
        at_cyc(16); req_a = 2'b00; check("a_pd_k16", 32'(pd_a), 32'h2);
        at_cyc(21); check("a_ph_k21", 32'(ph_a), 3); check("a_rd_k21", 32'(rd_a), 1);
                    check("a_l_k21", 32'(l_a), 32'h2); check("a_r_k21", 32'(r_a), 32'h3);
                    check("a_pd_k21", 32'(pd_a), 0);
                    check("b_g_k21", 32'(g_b), 32'h2); check("b_rd_k21", 32'(rd_b), 1);
        at_cyc(24); check("a_g_k24", 32'(g_a), 32'h2); check("a_ph_k24", 32'(ph_a), 0);

        // Road B: request for road 2 while road 1 is green.
        at_cyc(30); req_b = 3'b100;
        at_cyc(31); req_b = 3'b000; check("b_pd_k31", 32'(pd_b), 32'h4);
        at_cyc(38); check("a_ph_k38_skip_left", 32'(ph_a), 0); check("a_rd_k38", 32'(rd_a), 1);
        at_cyc(42); check("b_rd_k42", 32'(rd_b), 2); check("b_ph_k42", 32'(ph_b), 3);
                    check("b_l_k42", 32'(l_b), 32'h4); check("b_r_k42", 32'(r_b), 32'h7);
                    check("b_pd_k42", 32'(pd_b), 0);

        // Request on the exact cycle road 1 all-red expires.
        at_cyc(44); req_a = 2'b01; check("a_ph_k44", 32'(ph_a), 2); check("a_rd_k44", 32'(rd_a), 1);
        at_cyc(45); req_a = 2'b00;
                    check("a_ph_k45", 32'(ph_a), 3); check("a_rd_k45", 32'(rd_a), 0);
                    check("a_l_k45", 32'(l_a), 32'h1); check("a_pd_k45", 32'(pd_a), 0);

        // Road 1 request, then another while road 1 is in LEFT.
        at_cyc(62); req_a = 2'b10; check("a_ph_k62", 32'(ph_a), 0); check("a_rd_k62", 32'(rd_a), 0);
        at_cyc(63); req_a = 2'b00; check("a_pd_k63", 32'(pd_a), 32'h2);
                    check("b_ph_k63", 32'(ph_b), 1); check("b_rd_k63", 32'(rd_b), 2);
        at_cyc(70); req_a = 2'b10; check("a_ph_k70", 32'(ph_a), 3); check("a_rd_k70", 32'(rd_a), 1);
                    check("a_pd_k70", 32'(pd_a), 0);
        at_cyc(71); req_a = 2'b00; check("a_pd_k71", 32'(pd_a), 32'h2);
        at_cyc(72); check("b_rd_k72", 32'(rd_b), 0); check("b_g_k72", 32'(g_b), 32'h1);
        at_cyc(75); check("a_pd_k75", 32'(pd_a), 32'h2); check("a_ph_k75", 32'(ph_a), 0);
        at_cyc(86); check("a_ph_k86", 32'(ph_a), 3); check("a_rd_k86", 32'(rd_a), 1);

        // Reset mid-yellow of road 1 with both requests pending.
        at_cyc(89); req_a = 2'b11;
        at_cyc(90); req_a = 2'b00; check("a_pd_k90", 32'(pd_a), 32'h3);
        at_cyc(93); check("a_ph_k93", 32'(ph_a), 1); check("a_rd_k93", 32'(rd_a), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_g", 32'(g_a), 32'h1); check("rst_r", 32'(r_a), 32'h2);
        check("rst_y", 32'(y_a), 0);     check("rst_l", 32'(l_a), 0);
        check("rst_pd", 32'(pd_a), 0);   check("rst_ph", 32'(ph_a), 0);
        check("rst_rd", 32'(rd_a), 0);
        check("rst_b_g", 32'(g_b), 32'h1); check("rst_b_r", 32'(r_b), 32'h6);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Timing restarts from zero.
        at_cyc(3); check("post_g_k3", 32'(g_a), 32'h1); check("post_ph_k3", 32'(ph_a), 0);
        at_cyc(4); check("post_y_k4", 32'(y_a), 32'h1); check("post_ph_k4", 32'(ph_a), 1);
        at_cyc(7); check("post_rd_k7", 32'(rd_a), 1);   check("post_pd_k7", 32'(pd_a), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intersection_sequencer.md
Name: intersection_sequencer

Overview:
- Parametrised, clocked traffic-light sequencer for an intersection of NUM_ROADS approaches.
- Owns the phase state machine, tick prescaler, per-phase dwell timers and latched left-turn requests.
- Drives one green/red/yellow/left lamp bit per road; bit r is road r.
- Replaces the external 3-bit state bus plus combinational lamp decode with a self-timed controller that skips left-turn phases nobody requested.

Parameters:
NUM_ROADS, 2, number of approaches served round-robin (>=2)
TICK_DIV, 50000000, clock cycles per timing tick (>=1; 1 = tick every cycle)
GREEN_TICKS, 20, ticks spent in GREEN (>=1)
YELLOW_TICKS, 4, ticks spent in YELLOW (>=1)
ALLRED_TICKS, 2, ticks spent in ALLRED (>=1)
LEFT_TICKS, 8, ticks spent in LEFT (>=1)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces reset state immediately
leftReq  input  NUM_ROADS  left-turn request per road; a one-cycle pulse is sufficient
greenOut  output  NUM_ROADS  green lamp per road
redOut  output  NUM_ROADS  red lamp per road
yellowOut  output  NUM_ROADS  yellow lamp per road
leftOut  output  NUM_ROADS  protected-left arrow per road
roadOut  output  max(1,$clog2(NUM_ROADS))  index of the active road
phaseOut  output  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=LEFT
leftPending  output  NUM_ROADS  latched, not-yet-served left requests

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - road=0, phase=GREEN, dwell timer=0, prescaler=0, leftPending=0.
  - Outputs: greenOut=...0001, redOut=all ones except bit0, yellowOut=0, leftOut=0, roadOut=0, phaseOut=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 every cycle and wraps.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is permanently 1.
- Dwell timer:
  - Increments on tick.
  - When tick and timer==DUR(phase)-1: the phase advances on that edge and the timer clears to 0.
  - Each phase therefore lasts exactly DUR*TICK_DIV cycles.
  - Timer width is $clog2 of the largest duration, plus 1.
- Phase sequence for active road r:
  - LEFT -> GREEN -> YELLOW -> ALLRED -> next road.
  - Next road is nr = (r==NUM_ROADS-1) ? 0 : r+1. The wrap is explicit; no reliance on power-of-two width.
  - On ALLRED exit: road <= nr. Phase <= LEFT if leftPending[nr] or leftReq[nr] is high that cycle, else GREEN.
- Lamps (Moore; a function of the road/phase registers only):
  - Active road r in GREEN: green[r]=1. In YELLOW: yellow[r]=1. In LEFT: left[r]=1 and red[r]=1.
  - ALLRED: every road red, no other lamps.
  - Every non-active road: red=1, others 0.
  - Invariant: at most one bit set across greenOut|yellowOut|leftOut.
- Left requests:
  - leftPending[i] sets on leftReq[i].
  - leftPending[i] clears on the edge road i enters LEFT.
  - If a set and a clear coincide for the same bit, clear wins; the entering request is considered served.
  - A request for road r arriving while r is already in LEFT, GREEN, YELLOW or ALLRED is latched and served on r's next turn.
  - Multiple pulses before service collapse to one.
- Reset mid-operation: all registers return to reset values asynchronously. Pending requests are discarded. Lamps show road0 green in the same cycle reset asserts.
- No illegal states are reachable. If phase/road registers ever hold an out-of-range encoding, the next edge loads road 0, GREEN.

Test Plan:
Test parameters: TICK_DIV=1, GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1, LEFT_TICKS=3, NUM_ROADS=2, unless stated.
1. Release reset, no requests -> road0 GREEN 4 cycles, YELLOW 2, ALLRED 1, road1 GREEN 4 ... Full cycle is 14 clocks; greenOut sequence 01,10,01.
2. Pulse leftReq[1] for one cycle during road0 GREEN -> after road0 ALLRED: road1 LEFT for 3 cycles (leftOut=10, redOut=11), then GREEN. leftPending[1] drops on LEFT entry. Next road1 turn skips LEFT.
3. Pulse leftReq[0] on the exact cycle road1 ALLRED expires -> road0 enters LEFT directly. leftPending[0] stays 0.
4. Pulse leftReq[1] while road1 is in LEFT -> leftPending[1]=1 persists. Road1's next turn again starts with LEFT.
5. Assert reset mid-YELLOW of road1 with leftPending=11 -> same cycle: greenOut=01, redOut=10, leftPending=00, phaseOut=0. Timing restarts from 0 on release.
6. TICK_DIV=3, NUM_ROADS=3 -> each GREEN lasts 12 cycles. Road order is 0,1,2,0. Lamp invariant holds every cycle (assertion).
